// File: rtl/ftdi_parser_pkg.sv
// ftdi_parser_pkg: shared state encoding, error codes and default sync byte for the RX frame parser
package ftdi_parser_pkg;
  typedef enum logic [1:0] {IDLE, LEN, PAYLOAD, CHK} state_t;
  localparam logic [1:0] ERR_LEN = 2'd1;
  localparam logic [1:0] ERR_CHK = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
endpackage

// File: rtl/byte_out_reg.sv
// byte_out_reg: single-entry valid/ready register holding {last, data} for the payload stream
module byte_out_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [8:0] in_data,
  output logic       in_ready,
  input  logic       m_ready,
  output logic       m_valid,
  output logic [7:0] m_data,
  output logic       m_last
);
  assign in_ready = ~m_valid | m_ready;
  // load a new byte whenever the slot is empty or being drained this cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_last <= 1'b0;
      m_data <= '0;
    end else if (in_ready) begin
      m_valid <= in_valid;
      if (in_valid) {m_last, m_data} <= in_data;
    end
  end
endmodule

// File: rtl/ftdi_rx_frame_parser.sv
// ftdi_rx_frame_parser: sync-hunting, length-prefixed, checksummed frame parser on the FTDI RX byte stream
module ftdi_rx_frame_parser
  import ftdi_parser_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE = DEFAULT_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  output logic       rx_ready,
  input  logic [7:0] rx_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  state_t state, state_n;
  logic [7:0] cnt, acc, sum;
  logic [TW-1:0] tmo;
  logic en, rx_hs, out_ready, out_v, tmo_exp, ok_n, err_n;
  logic [1:0] code_n;
  assign rx_ready = en & ((state != PAYLOAD) | out_ready);
  assign rx_hs = rx_valid & rx_ready;
  assign sum = acc + rx_data;
  assign out_v = (state == PAYLOAD) & rx_hs;
  assign tmo_exp = (state != IDLE) & ~rx_valid & (tmo == TW'(TIMEOUT_CYCLES - 1));
  // state register and registered status pulses; en keeps rx_ready low through reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      en <= 1'b0;
      frame_ok <= 1'b0;
      frame_err <= 1'b0;
      err_code <= '0;
    end else begin
      state <= state_n;
      en <= 1'b1;
      frame_ok <= ok_n;
      frame_err <= err_n;
      err_code <= code_n;
    end
  end
  // length down-counter, checksum accumulator and inter-byte idle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
      tmo <= '0;
    end else begin
      if (state == LEN && rx_hs) begin
        cnt <= rx_data;
        acc <= rx_data;
      end else if (out_v) begin
        cnt <= cnt - 8'd1;
        acc <= sum;
      end
      tmo <= (state == IDLE || rx_hs) ? '0 : ~rx_valid ? tmo + TW'(1) : tmo;
    end
  end
  // next-state and status decode; timeout only fires on idle cycles so a handshake always wins
  always_comb begin
    state_n = state;
    ok_n = 1'b0;
    err_n = 1'b0;
    code_n = err_code;
    case (state)
      IDLE:    if (rx_hs && rx_data == SYNC_BYTE) state_n = LEN;
      LEN:     if (rx_hs) begin
                 state_n = (rx_data == 8'd0) ? IDLE : PAYLOAD;
                 err_n = (rx_data == 8'd0);
                 code_n = (rx_data == 8'd0) ? ERR_LEN : err_code;
               end
      PAYLOAD: if (rx_hs && cnt == 8'd1) state_n = CHK;
      CHK:     if (rx_hs) begin
                 state_n = IDLE;
                 ok_n = (sum == 8'd0);
                 err_n = (sum != 8'd0);
                 code_n = (sum != 8'd0) ? ERR_CHK : err_code;
               end
      default: state_n = IDLE;
    endcase
    if (tmo_exp) begin
      state_n = IDLE;
      err_n = 1'b1;
      code_n = ERR_TIMEOUT;
    end
  end
  byte_out_reg u_out (
    .clk(clk),
    .rst(rst),
    .in_valid(out_v),
    .in_data({cnt == 8'd1, rx_data}),
    .in_ready(out_ready),
    .m_ready(m_ready),
    .m_valid(m_valid),
    .m_data(m_data),
    .m_last(m_last)
  );
endmodule

// File: tb/tb_ftdi_rx_frame_parser.sv
// tb_ftdi_rx_frame_parser: directed self-checking bench for the FTDI RX frame parser
module tb_ftdi_rx_frame_parser;
  logic clk = 1'b0, rst = 1'b1, rx_valid = 1'b0, m_ready = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic rx_ready, m_valid, m_last, frame_ok, frame_err;
  logic [7:0] m_data;
  logic [1:0] err_code;
  int n_cmp = 0, n_bad = 0;
  logic [8:0] log_mem [0:255];
  int n_log = 0, n_ok = 0, n_err = 0;
  logic [1:0] last_code = 2'd0;
  int b, o, e;

  always #5 clk = ~clk;

  ftdi_rx_frame_parser #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code)
  );

  // log accepted payload bytes and count status pulses, sampled mid-cycle
  always @(negedge clk) begin
    if (m_valid && m_ready && n_log < 256) begin
      log_mem[n_log] = {m_last, m_data};
      n_log++;
    end
    if (frame_ok) n_ok++;
    if (frame_err) begin
      n_err++;
      last_code = err_code;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] v);
    int k;
    logic hs;
    rx_valid = 1'b1;
    rx_data = v;
    hs = 1'b0;
    k = 0;
    while (!hs && k < 200) begin
      @(negedge clk);
      hs = rx_ready;
      @(posedge clk);
      k++;
    end
    #1;
    rx_valid = 1'b0;
    if (!hs) chk("send_handshake", 32'(hs), 32'd1);
  endtask

  task automatic frame(input logic [7:0] c);
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(c);
  endtask

  task automatic expect_payload(input string tag, input int base);
    chk({tag, "_count"}, 32'(n_log - base), 32'd3);
    chk({tag, "_b0"}, 32'(log_mem[base]), 32'h011);
    chk({tag, "_b1"}, 32'(log_mem[base + 1]), 32'h022);
    chk({tag, "_b2_last"}, 32'(log_mem[base + 2]), 32'h133);
  endtask

  initial begin
    idle(3);
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_frame_ok", 32'(frame_ok), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    rst = 1'b0;
    idle(1);
    chk("rx_ready_after_rst", 32'(rx_ready), 32'd1);

    b = n_log; o = n_ok; e = n_err;
    send(8'hA5); send(8'h03); send(8'h11);
    chk("latency_m_valid", 32'(m_valid), 32'd1);
    chk("latency_m_data", 32'(m_data), 32'h11);
    send(8'h22); send(8'h33); send(8'h97);
    chk("good_ok_pulse", 32'(frame_ok), 32'd1);
    chk("good_no_err", 32'(frame_err), 32'd0);
    idle(3);
    chk("good_ok_once", 32'(n_ok - o), 32'd1);
    chk("good_err_none", 32'(n_err - e), 32'd0);
    expect_payload("good", b);

    b = n_log; o = n_ok; e = n_err;
    frame(8'h98);
    idle(3);
    expect_payload("badchk", b);
    chk("badchk_err", 32'(n_err - e), 32'd1);
    chk("badchk_code", 32'(last_code), 32'd2);
    chk("badchk_no_ok", 32'(n_ok - o), 32'd0);

    b = n_log; o = n_ok; e = n_err;
    send(8'h00); send(8'hFF); send(8'h5A);
    idle(2);
    chk("hunt_no_output", 32'(n_log - b), 32'd0);
    chk("hunt_no_err", 32'(n_err - e), 32'd0);
    frame(8'h97);
    idle(3);
    expect_payload("hunt", b);
    chk("hunt_ok", 32'(n_ok - o), 32'd1);

    b = n_log; o = n_ok; e = n_err;
    send(8'hA5); send(8'h00);
    chk("zlen_err_pulse", 32'(frame_err), 32'd1);
    chk("zlen_code", 32'(err_code), 32'd1);
    frame(8'h97);
    idle(3);
    expect_payload("zlen_next", b);
    chk("zlen_next_ok", 32'(n_ok - o), 32'd1);
    chk("zlen_err_count", 32'(n_err - e), 32'd1);

    b = n_log; o = n_ok; e = n_err;
    send(8'hA5); send(8'h03); send(8'h11);
    repeat (15) @(posedge clk);
    #1;
    chk("tmo_not_yet", 32'(frame_err), 32'd0);
    idle(1);
    chk("tmo_err_pulse", 32'(frame_err), 32'd1);
    chk("tmo_code", 32'(err_code), 32'd3);
    idle(2);
    chk("tmo_one_byte", 32'(n_log - b), 32'd1);
    chk("tmo_byte_no_last", 32'(log_mem[b]), 32'h011);
    b = n_log;
    frame(8'h97);
    idle(3);
    expect_payload("tmo_next", b);
    chk("tmo_next_ok", 32'(n_ok - o), 32'd1);
    chk("tmo_err_count", 32'(n_err - e), 32'd1);

    b = n_log; o = n_ok; e = n_err;
    m_ready = 1'b0;
    send(8'hA5); send(8'h03); send(8'h11);
    rx_valid = 1'b1;
    rx_data = 8'h22;
    idle(40);
    chk("bp_rx_ready_low", 32'(rx_ready), 32'd0);
    chk("bp_m_valid_held", 32'(m_valid), 32'd1);
    chk("bp_m_data_held", 32'(m_data), 32'h11);
    chk("bp_no_timeout", 32'(n_err - e), 32'd0);
    m_ready = 1'b1;
    send(8'h22); send(8'h33); send(8'h97);
    idle(3);
    expect_payload("bp", b);
    chk("bp_ok", 32'(n_ok - o), 32'd1);

    o = n_ok; e = n_err;
    m_ready = 1'b0;
    send(8'hA5); send(8'h03); send(8'h11);
    chk("mid_rst_pending", 32'(m_valid), 32'd1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("mid_rst_m_data", 32'(m_data), 32'd0);
    idle(3);
    chk("mid_rst_no_ok", 32'(n_ok - o), 32'd0);
    chk("mid_rst_no_err", 32'(n_err - e), 32'd0);
    m_ready = 1'b1;
    b = n_log;
    frame(8'h97);
    idle(3);
    expect_payload("post_rst", b);
    chk("post_rst_ok", 32'(n_ok - o), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
